// File: rtl/spram_arbiter_if.sv
// Bus bundle between the CPU data port, the DMA loader port and the SPRAM pins.
// The arbiter takes the slave view; requesters and the RAM take the master view.
interface spram_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [3:0]        cpu_wmask;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_valid;
    logic              dma_ready;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [3:0]        ram_maskwren;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        input  dma_valid, dma_we, dma_addr, dma_wdata,
        output dma_ready, dma_rvalid, dma_rdata,
        output ram_addr, ram_wdata, ram_maskwren, ram_wren,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        output dma_valid, dma_we, dma_addr, dma_wdata,
        input  dma_ready, dma_rvalid, dma_rdata,
        input  ram_addr, ram_wdata, ram_maskwren, ram_wren,
        output ram_rdata
    );
endinterface

// File: rtl/spram_arbiter.sv
// Single-SPRAM arbiter: CPU has fixed priority, DMA gets a forced slot after
// STARVE_LIMIT consecutive denied cycles. Read data returns one cycle after grant.
module spram_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk_cpu,
    input  logic            rst,
    spram_arbiter_if.slave  bus
);
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_DMA  = 2'd2;
    localparam logic [7:0] LIMIT    = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt;
    logic [1:0] owner_q;
    logic       starved;
    logic       grant_cpu;
    logic       grant_dma;

    assign starved   = (starve_cnt == LIMIT);
    assign grant_dma = bus.dma_valid & (~bus.cpu_req | starved) & ~rst;
    assign grant_cpu = bus.cpu_req & ~grant_dma & ~rst;

    assign bus.cpu_stall = bus.cpu_req & ~grant_cpu;
    assign bus.dma_ready = grant_dma;

    always_comb begin
        bus.ram_addr     = {ADDR_W{1'b0}};
        bus.ram_wdata    = {DATA_W{1'b0}};
        bus.ram_wren     = 1'b0;
        bus.ram_maskwren = 4'b0000;
        if (grant_cpu) begin
            bus.ram_addr     = bus.cpu_addr;
            bus.ram_wdata    = bus.cpu_wdata;
            bus.ram_wren     = bus.cpu_we;
            bus.ram_maskwren = bus.cpu_we ? bus.cpu_wmask : 4'b0000;
        end else if (grant_dma) begin
            bus.ram_addr     = bus.dma_addr;
            bus.ram_wdata    = bus.dma_wdata;
            bus.ram_wren     = bus.dma_we;
            bus.ram_maskwren = bus.dma_we ? 4'b1111 : 4'b0000;
        end
    end

    // Owner of the read currently in flight through the SPRAM output register,
    // plus the count of consecutive cycles the DMA port has been refused.
    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            starve_cnt <= 8'd0;
            owner_q    <= OWN_NONE;
        end else begin
            if (bus.dma_valid & ~grant_dma) begin
                if (!starved)
                    starve_cnt <= starve_cnt + 8'd1;
            end else begin
                starve_cnt <= 8'd0;
            end

            if (grant_cpu & ~bus.cpu_we)
                owner_q <= OWN_CPU;
            else if (grant_dma & ~bus.dma_we)
                owner_q <= OWN_DMA;
            else
                owner_q <= OWN_NONE;
        end
    end

    // A read in flight when reset arrives is dropped rather than delivered.
    assign bus.cpu_rvalid = (owner_q == OWN_CPU) & ~rst;
    assign bus.dma_rvalid = (owner_q == OWN_DMA) & ~rst;
    assign bus.cpu_rdata  = bus.ram_rdata;
    assign bus.dma_rdata  = bus.ram_rdata;
endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Shares the single up5k SB_SPRAM256KA data RAM between two requesters:
  - the CPU data port, which has fixed priority;
  - a secondary DMA port, intended for the video/debug loader, with a valid/ready handshake.
- Sits between the CPU top and the SPRAM primitive and drives its ADDRESS/DATAIN/MASKWREN/WREN pins.
- One SPRAM access per clock. A starvation guard bounds how long the DMA port can wait.
- Read data is returned one cycle after grant, because the SPRAM output is registered.

Parameters:
- ADDR_W, 14, SPRAM word address width.
- DATA_W, 16, data width.
- STARVE_LIMIT, 8, consecutive denied DMA cycles before DMA is forced a grant. Legal range 1..255.

Ports:
- clk_cpu  in  1  system clock; the SPRAM is clocked from the same net.
- rst  in  1  synchronous reset, active-high.
- cpu_req  in  1  CPU access request this cycle.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_wmask  in  4  nibble write enables (MASKWREN format).
- cpu_stall  out  1  CPU request not accepted this cycle; CPU must hold its inputs.
- cpu_rvalid  out  1  cpu_rdata valid.
- cpu_rdata  out  DATA_W  read data.
- dma_valid  in  1  DMA request.
- dma_ready  out  1  DMA request accepted this cycle.
- dma_we  in  1  DMA write.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data; DMA writes use the full mask 4'b1111.
- dma_rvalid  out  1  dma_rdata valid.
- dma_rdata  out  DATA_W  read data.
- ram_addr  out  ADDR_W  to SPRAM ADDRESS.
- ram_wdata  out  DATA_W  to SPRAM DATAIN.
- ram_maskwren  out  4  to SPRAM MASKWREN.
- ram_wren  out  1  to SPRAM WREN.
- ram_rdata  in  DATA_W  from SPRAM DATAOUT.

Behaviour:
- Clock and reset: single clock clk_cpu; reset rst is synchronous and active-high.

Grant selection (combinational, once per cycle):
- Let starved = (starve_cnt == STARVE_LIMIT).
- grant_dma = dma_valid & (~cpu_req | starved) & ~rst.
- grant_cpu = cpu_req & ~grant_dma & ~rst.
- cpu_stall = cpu_req & ~grant_cpu.
- dma_ready = grant_dma.
- A request is accepted in the cycle its grant is high. A requester must hold its inputs stable until accepted.

SPRAM drive (combinational mux from the granted port):
- CPU granted: ram_addr = cpu_addr, ram_wdata = cpu_wdata, ram_wren = cpu_we, ram_maskwren = cpu_we ? cpu_wmask : 4'b0000.
- DMA granted: ram_addr = dma_addr, ram_wdata = dma_wdata, ram_wren = dma_we, ram_maskwren = dma_we ? 4'b1111 : 4'b0000.
- Nothing granted: all RAM outputs are 0, with ram_wren = 0 and ram_maskwren = 0.

Starvation counter (starve_cnt, 8 bits, registered):
- Reset value 0.
- If dma_valid & ~grant_dma: increment, saturating at STARVE_LIMIT.
- Otherwise: clear to 0. This covers a DMA grant and dma_valid low.
- A forced DMA grant therefore occurs at most once per STARVE_LIMIT+1 cycles of continuous CPU traffic. During a forced grant, cpu_stall = 1 for exactly that cycle.

Read return:
- Registered owner_q ∈ {NONE, CPU, DMA}; reset value NONE.
- On the next edge, owner_q <= CPU if grant_cpu & ~cpu_we, DMA if grant_dma & ~dma_we, NONE otherwise.
- cpu_rvalid = (owner_q == CPU); dma_rvalid = (owner_q == DMA).
- cpu_rdata = dma_rdata = ram_rdata (passthrough). Data is meaningful only while the matching rvalid is high.
- Latency: a read granted in cycle N returns with rvalid in cycle N+1.
- Back-to-back reads, including alternating owners, return in grant order with no bubbles.
- Writes never raise rvalid. A write is complete at the grant edge. A read of the same address in the following cycle returns the new data.

Reset:
- While rst = 1: no grants, ram_wren = 0, dma_ready = 0, cpu_stall = cpu_req.
- Reset mid-read: owner_q is forced to NONE, so the pending rvalid is dropped and never delivered after reset.

Boundaries:
- Simultaneous requests, not starved: CPU wins and DMA waits.
- Address 0x3FFF and address 0 have no special handling.
- Once starve_cnt saturates, it holds at STARVE_LIMIT until a DMA grant or until dma_valid drops.

Test Plan:
- CPU write 0x1234 to 0x0010 with mask 1111, then read 0x0010 → ram_wren high in write cycle; next cycle cpu_rvalid = 1, cpu_rdata = 0x1234; cpu_stall always 0.
- CPU idle, DMA write 0xBEEF to 0x3FFF, then DMA read → dma_ready high both cycles; dma_rvalid one cycle after the read with 0xBEEF; cpu_rvalid stays 0.
- Continuous CPU reads plus dma_valid held, STARVE_LIMIT = 8 → dma_ready first asserts in the 9th cycle of contention; cpu_stall = 1 in exactly that cycle; starve_cnt returns to 0.
- CPU write with cpu_wmask = 0011 over existing 0xFFFF, data 0x0000 → readback 0xFF00.
- Alternating grants CPU read A, DMA read B, CPU read C (forced DMA via starvation) → cpu_rvalid, dma_rvalid, cpu_rvalid on consecutive cycles with the correct data.
- CPU read granted, then rst asserted on the next cycle → cpu_rvalid stays 0; ram_wren = 0 and dma_ready = 0 throughout reset.
